// File: rtl/alu_self_test_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_self_test_if                                           |
// | Description : Bus between the ALU self-test initiator and the 4-bit ALU. |
// |               master = self-test (drives operands/op/load strobe,        |
// |               samples result); slave = ALU.                              |
// |   in1, in2  : 4-bit operands            ctrl    : 2-bit op select      |
// |   toggle    : ALU load strobe           alu_out : 4-bit result         |
// |   alu_cf    : carry flag                alu_z   : zero flag            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface alu_self_test_if;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [1:0] ctrl;
  logic       toggle;
  logic [3:0] alu_out;
  logic       alu_cf;
  logic       alu_z;

  modport master (output in1, in2, ctrl, toggle, input alu_out, alu_cf, alu_z);
  modport slave  (input in1, in2, ctrl, toggle, output alu_out, alu_cf, alu_z);
endinterface
`default_nettype wire

// File: rtl/alu_self_test.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_self_test                                              |
// | Description : On-chip initiator for the 4-bit ALU. Replays a fixed       |
// |               26-vector ADD/AND/NOT/ZERO suite, compares OUT/CF/Z with   |
// |               an internal reference model and reports the outcome.       |
// | Ports       : clk_i, rst_i (async, active high), start_i (level)         |
// |               alu        : master side of alu_self_test_if               |
// |               busy_o     : run in progress                               |
// |               done_o     : run finished (held until START or reset)      |
// |               pass_o     : with done_o, 1 iff no vector failed           |
// |               fail_cnt_o : failing vectors this run (saturating)         |
// |               vec_idx_o  : index of the vector being applied             |
// |               err_vec_o  : index of the first failing vector             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module alu_self_test #(
  parameter int TOGGLE_CYCLES = 10,
  parameter int SETTLE_CYCLES = 100,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  alu_self_test_if.master alu,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [4:0]      fail_cnt_o,
  output logic [4:0]      vec_idx_o,
  output logic [4:0]      err_vec_o
);

  localparam logic [4:0] LAST_VEC = 5'd25;
  localparam logic [4:0] FAIL_MAX = 5'd31;
  localparam int MAX_WAIT = (TOGGLE_CYCLES > SETTLE_CYCLES) ? TOGGLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] TOGGLE_LAST = CNT_W'(TOGGLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PULSE  = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Vector ROM: returns {ctrl, in1, in2}. ADD and AND share one operand-pair
  // table, NOT and ZERO share one IN1 table with IN2 = 0.
  function automatic logic [9:0] vec_rom(input logic [4:0] idx);
    logic [1:0] op;
    logic [2:0] k;
    logic [3:0] a;
    logic [3:0] b;
    if (idx < 5'd7) begin
      op = 2'b00; k = idx[2:0];
    end else if (idx < 5'd14) begin
      op = 2'b01; k = 3'(idx - 5'd7);
    end else if (idx < 5'd20) begin
      op = 2'b10; k = 3'(idx - 5'd14);
    end else begin
      op = 2'b11; k = 3'(idx - 5'd20);
    end
    a = 4'h0;
    b = 4'h0;
    if (!op[1]) begin
      case (k)
        3'd0:    begin a = 4'h0; b = 4'h0; end
        3'd1:    begin a = 4'hF; b = 4'h0; end
        3'd2:    begin a = 4'h0; b = 4'hF; end
        3'd3:    begin a = 4'hC; b = 4'h3; end
        3'd4:    begin a = 4'h9; b = 4'h3; end
        3'd5:    begin a = 4'h4; b = 4'hF; end
        default: begin a = 4'hF; b = 4'hF; end
      endcase
    end else begin
      case (k)
        3'd0:    a = 4'h0;
        3'd1:    a = 4'h1;
        3'd2:    a = 4'h3;
        3'd3:    a = 4'h7;
        3'd4:    a = 4'h9;
        default: a = 4'hF;
      endcase
    end
    return {op, a, b};
  endfunction

  // Expected ALU response as {cf, z, out}.
  function automatic logic [5:0] ref_model(input logic [1:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
    logic [4:0] sum;
    logic [3:0] r;
    logic       c;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      2'b00:   begin r = sum[3:0]; c = sum[4]; end
      2'b01:   begin r = a & b;    c = 1'b0;   end
      2'b10:   begin r = ~a;       c = 1'b0;   end
      default: begin r = 4'h0;     c = 1'b0;   end
    endcase
    return {c, (r == 4'h0), r};
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       fail_q, fail_d;
  logic [4:0]       err_q, err_d;
  logic [3:0]       in1_q, in1_d;
  logic [3:0]       in2_q, in2_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [4:0]       next_idx;
  logic             mismatch;

  assign next_idx = vec_q + 5'd1;
  assign mismatch = ({alu.alu_cf, alu.alu_z, alu.alu_out} != ref_model(ctrl_q, in1_q, in2_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      vec_q   <= 5'd0;
      cnt_q   <= '0;
      fail_q  <= 5'd0;
      err_q   <= 5'd0;
      in1_q   <= 4'h0;
      in2_q   <= 4'h0;
      ctrl_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    err_d   = err_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          // New run: all run results cleared as the first vector is loaded.
          state_d                 = S_LOAD;
          vec_d                   = 5'd0;
          fail_d                  = 5'd0;
          err_d                   = 5'd0;
          {ctrl_d, in1_d, in2_d}  = vec_rom(5'd0);
        end
      end
      S_LOAD: begin
        state_d = S_PULSE;
        cnt_d   = '0;
      end
      S_PULSE: begin
        if (cnt_q == TOGGLE_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (fail_q != FAIL_MAX) fail_d = fail_q + 5'd1;
          // Count still zero means this is the first mismatch of the run.
          if (fail_q == 5'd0)     err_d  = vec_q;
        end
        if ((vec_q == LAST_VEC) || (mismatch && STOP_ON_FAIL)) begin
          state_d = S_DONE;
        end else begin
          state_d                = S_LOAD;
          vec_d                  = next_idx;
          {ctrl_d, in1_d, in2_d} = vec_rom(next_idx);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu.in1    = in1_q;
  assign alu.in2    = in2_q;
  assign alu.ctrl   = ctrl_q;
  assign alu.toggle = (state_q == S_PULSE);

  assign busy_o     = (state_q == S_LOAD) || (state_q == S_PULSE) ||
                      (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done_o     = (state_q == S_DONE);
  assign pass_o     = (state_q == S_DONE) && (fail_q == 5'd0);
  assign fail_cnt_o = fail_q;
  assign vec_idx_o  = vec_q;
  assign err_vec_o  = err_q;

endmodule
`default_nettype wire
